// File: rtl/commit_halt_monitor_if.sv
// Commit-stream bundle between the retiring core lanes and the halt monitor.
interface commit_halt_monitor_if #(
  parameter int NUM_CH  = 2,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64
);
  logic [NUM_CH-1:0]              commit_valid;
  logic [NUM_CH-1:0][31:0]        commit_instr;
  logic [NUM_CH-1:0][XLEN-1:0]    commit_pc;
  logic [NUM_CH-1:0][XLEN-1:0]    commit_pc_wdata;
  logic [NUM_CH-1:0][ORDER_W-1:0] lane_order;
  logic [ORDER_W-1:0]             order_count;
  logic                           halt;
  logic                           timeout;
  logic [1:0]                     mon_state;

  modport master (
    output commit_valid, commit_instr, commit_pc, commit_pc_wdata,
    input  lane_order, order_count, halt, timeout, mon_state
  );

  modport slave (
    input  commit_valid, commit_instr, commit_pc, commit_pc_wdata,
    output lane_order, order_count, halt, timeout, mon_state
  );
endinterface

// File: rtl/commit_halt_monitor.sv
// Commit-stream monitor: retirement ordering, self-loop halt detection with
// drain, and a no-commit watchdog.
module commit_halt_monitor_lane #(
  parameter int XLEN     = 32,
  parameter int LOOP_JAL = 1
) (
  input  logic            valid,
  input  logic [6:0]      opcode,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_wdata,
  output logic            hit
);
  logic loop_op;
  assign loop_op = (opcode == 7'h63) || ((LOOP_JAL != 0) && (opcode == 7'h6f));
  // valid gates first so garbage on idle lanes never reaches state
  assign hit = valid && loop_op && (pc_wdata == pc);
endmodule

module commit_halt_monitor #(
  parameter int NUM_CH        = 2,
  parameter int XLEN          = 32,
  parameter int ORDER_W       = 64,
  parameter int DRAIN_CYCLES  = 5,
  parameter int STALL_TIMEOUT = 100000,
  parameter int LOOP_JAL      = 1
) (
  input  logic                clk,
  input  logic                rst,
  commit_halt_monitor_if.slave mon
);
  localparam int CNT_W = $clog2(NUM_CH + 1);
  localparam int DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam int STL_W = (STALL_TIMEOUT > 1) ? $clog2(STALL_TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2, TMO = 2'd3} state_t;

  state_t                          state;
  logic [ORDER_W-1:0]              cnt;
  logic [DRN_W-1:0]                drain_cnt;
  logic [STL_W-1:0]                stall_cnt;
  logic [NUM_CH-1:0]               hit;
  logic [NUM_CH:0][CNT_W-1:0]      pre;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    commit_halt_monitor_lane #(.XLEN(XLEN), .LOOP_JAL(LOOP_JAL)) u_lane (
      .valid    (mon.commit_valid[i]),
      .opcode   (mon.commit_instr[i][6:0]),
      .pc       (mon.commit_pc[i]),
      .pc_wdata (mon.commit_pc_wdata[i]),
      .hit      (hit[i])
    );
  end

  // Prefix popcount compacts order numbers across valid lanes
  always_comb begin
    pre[0] = '0;
    for (int i = 0; i < NUM_CH; i++)
      pre[i+1] = pre[i] + CNT_W'(mon.commit_valid[i]);
  end

  always_comb begin
    mon.lane_order = '0;
    for (int i = 0; i < NUM_CH; i++)
      mon.lane_order[i] = cnt + ORDER_W'(pre[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + ORDER_W'(pre[NUM_CH]);
          if (|hit) begin
            state     <= DRAIN;
            drain_cnt <= DRN_W'(DRAIN_CYCLES);
          end else if (STALL_TIMEOUT != 0) begin
            if (|mon.commit_valid)                          stall_cnt <= '0;
            else if (stall_cnt == STL_W'(STALL_TIMEOUT - 1)) state     <= TMO;
            else                                            stall_cnt <= stall_cnt + STL_W'(1);
          end
        end
        DRAIN: begin
          cnt <= cnt + ORDER_W'(pre[NUM_CH]);
          if (drain_cnt == '0) state     <= HALTED;
          else                 drain_cnt <= drain_cnt - DRN_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mon.order_count = cnt;
  assign mon.halt        = (state == HALTED);
  assign mon.timeout     = (state == TMO);
  assign mon.mon_state   = state;
endmodule

// File: tb/tb_commit_halt_monitor.sv
// Two monitor instances (wide counter/JAL loops/watchdog vs 4-bit counter/
// branch-only/zero drain) driven by one stream and checked against a model.
module tb_commit_halt_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]       v;
  logic [1:0][31:0] ins, pc, wd;

  commit_halt_monitor_if #(.NUM_CH(2), .XLEN(32), .ORDER_W(64)) ifa ();
  commit_halt_monitor_if #(.NUM_CH(2), .XLEN(32), .ORDER_W(4))  ifb ();

  assign ifa.commit_valid = v;  assign ifb.commit_valid = v;
  assign ifa.commit_instr = ins; assign ifb.commit_instr = ins;
  assign ifa.commit_pc = pc;    assign ifb.commit_pc = pc;
  assign ifa.commit_pc_wdata = wd; assign ifb.commit_pc_wdata = wd;

  commit_halt_monitor #(.NUM_CH(2), .XLEN(32), .ORDER_W(64), .DRAIN_CYCLES(5),
                        .STALL_TIMEOUT(8), .LOOP_JAL(1))
    dut_a (.clk(clk), .rst(rst), .mon(ifa.slave));
  commit_halt_monitor #(.NUM_CH(2), .XLEN(32), .ORDER_W(4), .DRAIN_CYCLES(0),
                        .STALL_TIMEOUT(0), .LOOP_JAL(0))
    dut_b (.clk(clk), .rst(rst), .mon(ifb.slave));

  // reference model: per instance, mode 0 run /1 drain /2 halted /3 timed out
  int          p_drain[2] = '{5, 0};
  int          p_stall[2] = '{8, 0};
  int          p_jal[2]   = '{1, 0};
  int          p_ow[2]    = '{64, 4};
  logic [63:0] mcnt[2];
  int          mmode[2], mleft[2], midle[2];
  int          total = 0, passed = 0;

  function automatic logic [63:0] mask(input int m);
    return (p_ow[m] >= 64) ? '1 : ((64'd1 << p_ow[m]) - 64'd1);
  endfunction

  function automatic bit any_loop(input int m);
    bit r = 0;
    for (int i = 0; i < 2; i++)
      if (v[i] && (ins[i][6:0] == 7'h63 || (p_jal[m] == 1 && ins[i][6:0] == 7'h6f)) && wd[i] == pc[i])
        r = 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = '0; mmode[m] = 0; mleft[m] = 0; midle[m] = 0;
    end
  endtask

  task automatic model_step();
    int pop;
    pop = $countones(v);
    for (int m = 0; m < 2; m++) begin
      if (mmode[m] == 0) begin
        mcnt[m] = (mcnt[m] + 64'(pop)) & mask(m);
        if (any_loop(m)) begin
          mmode[m] = 1; mleft[m] = p_drain[m] + 1;
        end else if (pop == 0) begin
          midle[m]++;
          if (p_stall[m] != 0 && midle[m] >= p_stall[m]) mmode[m] = 3;
        end else midle[m] = 0;
      end else if (mmode[m] == 1) begin
        mcnt[m] = (mcnt[m] + 64'(pop)) & mask(m);
        mleft[m]--;
        if (mleft[m] == 0) mmode[m] = 2;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_inst(input int m, input logic [63:0] lo0, input logic [63:0] lo1,
                          input logic [63:0] oc, input logic h, input logic t,
                          input logic [1:0] st);
    string n;
    n = (m == 0) ? "a" : "b";
    if (v[0]) chk({n, "_lane0"}, lo0, mcnt[m]);
    if (v[1]) chk({n, "_lane1"}, lo1, (mcnt[m] + 64'(v[0])) & mask(m));
    chk({n, "_count"}, oc, mcnt[m]);
    chk({n, "_halt"}, 64'(h), 64'(mmode[m] == 2));
    chk({n, "_timeout"}, 64'(t), 64'(mmode[m] == 3));
    chk({n, "_state"}, 64'(st), 64'(mmode[m]));
  endtask

  task automatic check_all();
    chk_inst(0, ifa.lane_order[0], ifa.lane_order[1], ifa.order_count, ifa.halt, ifa.timeout, ifa.mon_state);
    chk_inst(1, 64'(ifb.lane_order[0]), 64'(ifb.lane_order[1]), 64'(ifb.order_count),
             ifb.halt, ifb.timeout, ifb.mon_state);
  endtask

  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // non-looping traffic; idle lanes carry X
  task automatic rnd_lanes(input logic [1:0] valid);
    logic [6:0] ops[4] = '{7'h13, 7'h33, 7'h63, 7'h6f};
    v = valid;
    for (int i = 0; i < 2; i++) begin
      if (valid[i]) begin
        ins[i] = {$urandom_range(0, 32'h1ffffff), ops[$urandom_range(0, 3)]};
        pc[i]  = {$urandom_range(0, 32'h3fffffff), 2'b00};
        wd[i]  = pc[i] + 32'd4;
      end else begin
        ins[i] = 'x; pc[i] = 'x; wd[i] = 'x;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; v = '0;
    #1 model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    v = '0; ins = '0; pc = '0; wd = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1 check_all();
    chk("reset_state", 64'(ifa.mon_state), 64'd0);
    rst = 1'b0;

    // compacted ordering
    for (int k = 0; k < 3; k++) begin
      rnd_lanes(2'b11);
      #1 chk("pair_lo", ifa.lane_order[0], 64'(2*k));
      chk("pair_hi", ifa.lane_order[1], 64'(2*k+1));
      tick();
    end
    rnd_lanes(2'b01);
    #1 chk("single_lane0", ifa.lane_order[0], 64'd6);
    tick();
    chk("count7", ifa.order_count, 64'd7);
    rnd_lanes(2'b11); tick();
    rnd_lanes(2'b01); tick();
    rnd_lanes(2'b10);
    #1 chk("lane1_only", ifa.lane_order[1], 64'd10);
    tick();
    chk("count11", ifa.order_count, 64'd11);

    // random traffic, also wraps the 4-bit counter
    for (int k = 0; k < 40; k++) begin
      rnd_lanes(2'($urandom_range(1, 3)));
      tick();
    end

    // branch to pc+4 is not a loop
    rnd_lanes(2'b10);
    ins[1] = 32'h00000063; pc[1] = 32'h60; wd[1] = 32'h64;
    tick();
    chk("no_loop_pc4", 64'(ifa.mon_state), 64'd0);

    // BEQ self-loop on lane 1
    rnd_lanes(2'b11);
    ins[1] = 32'h00000063; pc[1] = 32'h60; wd[1] = 32'h60;
    tick();
    chk("beq_drain_a", 64'(ifa.mon_state), 64'd1);
    chk("beq_drain_b", 64'(ifb.mon_state), 64'd1);
    for (int e = 1; e <= 6; e++) begin
      rnd_lanes(2'b11);
      tick();
      chk("drain_halt_edge", 64'(ifa.halt), 64'(e == 6));
    end
    for (int k = 0; k < 3; k++) begin
      rnd_lanes(2'b11); tick();
    end

    // JAL self-loop: only the LOOP_JAL instance reacts
    do_reset();
    rnd_lanes(2'b01);
    ins[0] = 32'h0000006f; pc[0] = 32'h80; wd[0] = 32'h80;
    tick();
    chk("jal_a", 64'(ifa.mon_state), 64'd1);
    chk("jal_b", 64'(ifb.mon_state), 64'd0);
    rnd_lanes(2'b11); tick();
    rnd_lanes(2'b11); tick();

    // asynchronous reset mid-drain
    #2 rst = 1'b1;
    #1 model_reset();
    chk("async_state", 64'(ifa.mon_state), 64'd0);
    chk("async_count", ifa.order_count, 64'd0);
    chk("async_halt", 64'(ifa.halt), 64'd0);
    chk("async_count_b", 64'(ifb.order_count), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    rnd_lanes(2'b11);
    #1 chk("restart_lo", ifa.lane_order[0], 64'd0);
    chk("restart_hi", ifa.lane_order[1], 64'd1);
    tick();

    // watchdog expiry after 8 idle edges
    do_reset();
    for (int k = 0; k < 7; k++) begin
      rnd_lanes(2'b00); tick();
    end
    chk("idle7_no_to", 64'(ifa.timeout), 64'd0);
    rnd_lanes(2'b00); tick();
    chk("idle8_to", 64'(ifa.timeout), 64'd1);
    chk("idle8_state", 64'(ifa.mon_state), 64'd3);
    chk("idle8_halt", 64'(ifa.halt), 64'd0);
    chk("b_no_watchdog", 64'(ifb.mon_state), 64'd0);
    rnd_lanes(2'b11); tick();

    // commit on cycle 7 clears the watchdog
    do_reset();
    for (int k = 0; k < 6; k++) begin
      rnd_lanes(2'b00); tick();
    end
    rnd_lanes(2'b01); tick();
    for (int k = 0; k < 7; k++) begin
      rnd_lanes(2'b00); tick();
    end
    chk("cleared_no_to", 64'(ifa.timeout), 64'd0);
    rnd_lanes(2'b00); tick();
    chk("cleared_then_to", 64'(ifa.timeout), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
